// File: rtl/pic10_pkg.sv
// pic10_pkg: shared constants for the pic10 pin-facing peripherals.
package pic10_pkg;
  localparam logic [4:0] PORT5_ADDR = 5'h05;
  localparam logic [4:0] PORT6_ADDR = 5'h06;
  localparam logic [4:0] PORT7_ADDR = 5'h07;
  localparam logic [2:0] TRIS_SEL5 = 3'd5;
  localparam logic [2:0] TRIS_SEL6 = 3'd6;
  localparam logic [2:0] TRIS_SEL7 = 3'd7;
  localparam logic [7:0] TRIS_RESET_DEFAULT = 8'hFF;
  localparam int SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/pic10_sync_bus.sv
// pic10_sync_bus: WIDTH-bit multi-flop synchronizer with async active-low reset.
module pic10_sync_bus #(
  parameter int WIDTH = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_stage [STAGES];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end
  assign o_q = r_stage[STAGES-1];
endmodule

// File: rtl/pic10_gpio_port.sv
// pic10_gpio_port: bidirectional GPIO port with TRIS, synchronized reads and masked change flag.
module pic10_gpio_port
  import pic10_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] TRIS_RESET  = TRIS_RESET_DEFAULT,
  parameter int               SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] pin_bus,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_port,
  input  logic             wr_tris,
  input  logic             wr_ioc,
  input  logic             rd_port,
  output logic [WIDTH-1:0] data_out,
  output logic             change_flag
);
  logic [WIDTH-1:0] r_tris, r_latch, r_ioc, r_snap, r_data_out;
  logic             r_flag;
  logic [WIDTH-1:0] w_sync, w_mismatch;

  pic10_sync_bus #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (pin_bus),
    .o_q  (w_sync)
  );

  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    assign pin_bus[g] = r_tris[g] ? 1'bz : r_latch[g];
  end

  // Only enabled input bits can raise the flag; outputs never count as changes.
  assign w_mismatch = (w_sync ^ r_snap) & r_tris & r_ioc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tris     <= TRIS_RESET;
      r_latch    <= '0;
      r_ioc      <= '0;
      r_snap     <= '0;
      r_data_out <= '0;
      r_flag     <= 1'b0;
    end else begin
      if (wr_port) r_latch <= data_in;
      if (wr_tris) r_tris <= data_in;
      if (wr_ioc) r_ioc <= data_in;
      if (rd_port) begin
        r_data_out <= w_sync;
        r_snap     <= w_sync;
        r_flag     <= 1'b0;
      end else begin
        r_flag <= r_flag | (|w_mismatch);
      end
    end
  end

  assign data_out    = r_data_out;
  assign change_flag = r_flag;
endmodule

// File: tb/tb_pic10_gpio_port.sv
// tb_pic10_gpio_port: directed plus randomized checks against a queue-based port model.
module tb_pic10_gpio_port;
  logic       clk = 1'b0;
  logic       reset;
  wire  [7:0] pin_bus;
  logic [7:0] data_in;
  logic       wr_port, wr_tris, wr_ioc, rd_port;
  logic [7:0] data_out;
  logic       change_flag;

  logic [7:0] ext;
  logic [7:0] m_tris, m_latch, m_ioc, m_snap, m_dout;
  logic       m_flag;
  logic [7:0] m_pipe [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pic10_gpio_port dut (
    .clk        (clk),
    .reset      (reset),
    .pin_bus    (pin_bus),
    .data_in    (data_in),
    .wr_port    (wr_port),
    .wr_tris    (wr_tris),
    .wr_ioc     (wr_ioc),
    .rd_port    (rd_port),
    .data_out   (data_out),
    .change_flag(change_flag)
  );

  // The outside world drives every released pin; idle value 1 stands in for the pull-ups.
  for (genvar g = 0; g < 8; g++) begin : g_ext
    assign pin_bus[g] = m_tris[g] ? ext[g] : 1'bz;
  end

  function automatic logic [7:0] m_pins();
    return (m_tris & ext) | (~m_tris & m_latch);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tris  = 8'hFF;
    m_latch = 8'h00;
    m_ioc   = 8'h00;
    m_snap  = 8'h00;
    m_dout  = 8'h00;
    m_flag  = 1'b0;
    m_pipe  = '{8'h00, 8'h00};
  endtask

  task automatic step(input logic [7:0] d, input logic wp, input logic wt,
                      input logic wi, input logic rd);
    logic [7:0] pins, seen;
    data_in = d;
    wr_port = wp;
    wr_tris = wt;
    wr_ioc  = wi;
    rd_port = rd;
    pins = m_pins();
    @(posedge clk);
    #1;
    seen = m_pipe[0];
    if (rd) begin
      m_dout = seen;
      m_snap = seen;
      m_flag = 1'b0;
    end else if (((seen ^ m_snap) & m_tris & m_ioc) != 8'h00) begin
      m_flag = 1'b1;
    end
    if (wp) m_latch = d;
    if (wt) m_tris = d;
    if (wi) m_ioc = d;
    void'(m_pipe.pop_front());
    m_pipe.push_back(pins);
    @(negedge clk);
    check("data_out", data_out, m_dout);
    check("change_flag", {7'b0, change_flag}, {7'b0, m_flag});
    check("pins", pin_bus, m_pins());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    ext = 8'hFF;
    data_in = 8'h00;
    {wr_port, wr_tris, wr_ioc, rd_port} = 4'b0;
    model_reset();
    #1;
    check("rst_data_out", data_out, 8'h00);
    check("rst_flag", {7'b0, change_flag}, 8'h00);
    check("rst_pins", pin_bus, 8'hFF);
    @(negedge clk);
    reset = 1'b1;

    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("first_read", data_out, 8'hFF);
    check("first_flag", {7'b0, change_flag}, 8'h00);

    step(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drive_hi_nibble", {4'h0, pin_bus[7:4]}, 8'h0A);
    ext = 8'h0A;
    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mixed_read", data_out, 8'hAA);
    ext = 8'hFF;
    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mixed_read_pullup", data_out, 8'hAF);

    step(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    ext = 8'hFE;
    idle(2);
    check("flag_two_edges", {7'b0, change_flag}, 8'h00);
    idle(1);
    check("flag_three_edges", {7'b0, change_flag}, 8'h01);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clear_flag", {7'b0, change_flag}, 8'h00);
    check("read_fe", data_out, 8'hFE);

    ext = 8'hFC;
    idle(4);
    check("masked_bit1", {7'b0, change_flag}, 8'h00);
    step(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mask_write_edge", {7'b0, change_flag}, 8'h00);
    idle(1);
    check("mask_enable_sets", {7'b0, change_flag}, 8'h01);

    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
    ext = 8'hFD;
    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("same_edge_flag", {7'b0, change_flag}, 8'h00);
    check("same_edge_read", data_out, 8'hFD);
    idle(3);
    check("no_spurious", {7'b0, change_flag}, 8'h00);

    step(8'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    ext = ext ^ 8'h01;
    idle(3);
    check("pre_reset_flag", {7'b0, change_flag}, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    #1;
    check("async_flag", {7'b0, change_flag}, 8'h00);
    check("async_data_out", data_out, 8'h00);
    check("async_pins", pin_bus, ext);
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    check("post_reset_flag", {7'b0, change_flag}, 8'h00);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) ext = 8'($urandom);
      step(8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
